// File: rtl/uart_cmd_decoder.sv
// uart_cmd_decoder: decodes UART key bytes into a 4-deep one-hot command queue plus a held-direction output
module uart_cmd_decoder #(
   parameter int REPEAT_TICKS = 5,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] rx_data,
   input  logic       rx_valid,
   input  logic       tick,
   input  logic       cmd_ready,
   output logic [7:0] cmd,
   output logic       cmd_valid,
   output logic [3:0] move_hold,
   output logic [2:0] fifo_count,
   output logic       overflow
);
   localparam int CW = $clog2(REPEAT_TICKS + 1);
   typedef enum logic {IDLE, HOLD} state_t;
   logic [7:0]    lc, dec;
   logic [7:0]    mem_q [4];
   logic [1:0]    wr_q, rd_q;
   logic [2:0]    cnt_q, cnt_d;
   logic          ovf_q, push, pop, full, wr_en, dir;
   state_t        state_q, state_d;
   logic [3:0]    hold_q, hold_d;
   logic [CW-1:0] hcnt_q, hcnt_d;

   // case-folded key decode and queue push/pop arbitration
   always_comb begin
      lc    = rx_data | 8'h20;
      dec   = {lc == 8'h68, rx_data == 8'h20, lc == 8'h78, rx_data == 8'h0D,
               lc == 8'h64, lc == 8'h61, lc == 8'h73, lc == 8'h77};
      full  = cnt_q == 3'(FIFO_DEPTH);
      push  = rx_valid & |dec;
      pop   = cmd_valid & cmd_ready;
      wr_en = push & (~full | pop);
      cnt_d = cnt_q + 3'(wr_en) - 3'(pop);
      dir   = rx_valid & |dec[3:0];
   end

   // queue pointers, occupancy and sticky drop flag
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
         ovf_q <= 1'b0;
      end else begin
         wr_q  <= wr_q + 2'(wr_en);
         rd_q  <= rd_q + 2'(pop);
         cnt_q <= cnt_d;
         ovf_q <= ovf_q | (push & full & ~pop);
      end
   end

   // queue storage; contents are masked by occupancy so they need no reset
   always_ff @(posedge clk) begin
      if (wr_en) mem_q[wr_q] <= dec;
   end

   // hold FSM next state: a direction key reloads, ticks count the hold down
   always_comb begin
      state_d = state_q;
      hold_d  = hold_q;
      hcnt_d  = hcnt_q;
      if (dir) begin
         state_d = HOLD;
         hold_d  = dec[3:0];
         hcnt_d  = CW'(REPEAT_TICKS);
      end else if (state_q == HOLD && tick) begin
         hcnt_d = hcnt_q - CW'(1);
         if (hcnt_q == CW'(1)) begin
            state_d = IDLE;
            hold_d  = '0;
         end
      end
   end

   // hold FSM state register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         hold_q  <= '0;
         hcnt_q  <= '0;
      end else begin
         state_q <= state_d;
         hold_q  <= hold_d;
         hcnt_q  <= hcnt_d;
      end
   end

   assign cmd_valid  = cnt_q != 3'd0;
   assign cmd        = cmd_valid ? mem_q[rd_q] : 8'h00;
   assign fifo_count = cnt_q;
   assign overflow   = ovf_q;
   assign move_hold  = hold_q;
endmodule

// File: tb/tb_uart_cmd_decoder.sv
// tb_uart_cmd_decoder: directed checks of decode, queue ordering, overflow, hold timing and async reset
module tb_uart_cmd_decoder;
   logic       clk = 1'b0, reset = 1'b1;
   logic [7:0] rx_data = 8'h00;
   logic       rx_valid = 1'b0, tick = 1'b0, cmd_ready = 1'b0;
   logic [7:0] cmd;
   logic       cmd_valid, overflow;
   logic [3:0] move_hold;
   logic [2:0] fifo_count;
   int         passed = 0, failed = 0, total = 0;

   uart_cmd_decoder dut (
      .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid), .tick(tick),
      .cmd_ready(cmd_ready), .cmd(cmd), .cmd_valid(cmd_valid), .move_hold(move_hold),
      .fifo_count(fifo_count), .overflow(overflow)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         failed++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic send(input logic [7:0] b, input logic rdy);
      rx_data = b; rx_valid = 1'b1; cmd_ready = rdy;
      @(negedge clk);
      rx_valid = 1'b0; cmd_ready = 1'b0;
   endtask

   task automatic tk();
      tick = 1'b1;
      @(negedge clk);
      tick = 1'b0;
   endtask

   task automatic drain(input logic [7:0] e0, input logic [7:0] e1, input logic [7:0] e2, input logic [7:0] e3);
      cmd_ready = 1'b1;
      chk("drain0", cmd, e0); @(negedge clk);
      chk("drain1", cmd, e1); @(negedge clk);
      chk("drain2", cmd, e2); @(negedge clk);
      chk("drain3", cmd, e3); @(negedge clk);
      cmd_ready = 1'b0;
      chk("drain_empty_valid", cmd_valid, 0);
      chk("drain_empty_cmd", cmd, 8'h00);
   endtask

   initial begin
      @(negedge clk); @(negedge clk);
      chk("rst_cmd", cmd, 8'h00);
      chk("rst_valid", cmd_valid, 0);
      chk("rst_count", fifo_count, 0);
      chk("rst_ovf", overflow, 0);
      chk("rst_hold", move_hold, 0);
      reset = 1'b0;
      @(negedge clk);
      send(8'h57, 1'b0);
      chk("W_valid", cmd_valid, 1);
      chk("W_cmd", cmd, 8'h01);
      chk("W_hold", move_hold, 4'b0001);
      chk("W_count", fifo_count, 1);
      cmd_ready = 1'b1; @(negedge clk); cmd_ready = 1'b0;
      chk("W_popped", cmd_valid, 0);
      send(8'h64, 1'b0); send(8'h20, 1'b0); send(8'h68, 1'b0); send(8'h78, 1'b0); send(8'h71, 1'b0);
      chk("seq_count", fifo_count, 4);
      chk("seq_ovf", overflow, 0);
      chk("seq_hold_q_ignored", move_hold, 4'b1000);
      drain(8'h08, 8'h40, 8'h80, 8'h20);
      send(8'h77, 1'b0); send(8'h73, 1'b0); send(8'h61, 1'b0); send(8'h64, 1'b0);
      chk("full_count", fifo_count, 4);
      chk("full_ovf0", overflow, 0);
      send(8'h73, 1'b0);
      chk("drop_ovf", overflow, 1);
      chk("drop_count", fifo_count, 4);
      chk("drop_hold", move_hold, 4'b0010);
      @(negedge clk);
      chk("stable_cmd", cmd, 8'h01);
      chk("stable_valid", cmd_valid, 1);
      send(8'h48, 1'b1);
      chk("pushpop_count", fifo_count, 4);
      chk("pushpop_ovf", overflow, 1);
      drain(8'h02, 8'h04, 8'h08, 8'h80);
      send(8'h61, 1'b0);
      chk("a_hold", move_hold, 4'b0100);
      for (int i = 1; i <= 4; i++) begin
         tk();
         chk($sformatf("tick%0d_hold", i), move_hold, 4'b0100);
      end
      tk();
      chk("tick5_hold", move_hold, 4'b0000);
      send(8'h61, 1'b0);
      tk(); tk();
      rx_data = 8'h61; rx_valid = 1'b1; tick = 1'b1;
      @(negedge clk);
      rx_valid = 1'b0; tick = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         tk();
         chk($sformatf("ext%0d_hold", i), move_hold, 4'b0100);
      end
      tk();
      chk("ext5_hold", move_hold, 4'b0000);
      chk("ext_count", fifo_count, 3);
      cmd_ready = 1'b1; repeat (3) @(negedge clk); cmd_ready = 1'b0;
      chk("ext_drained", fifo_count, 0);
      send(8'h77, 1'b0); send(8'h61, 1'b0); send(8'h73, 1'b0);
      chk("pre_rst_count", fifo_count, 3);
      chk("pre_rst_hold", move_hold, 4'b0010);
      #2 reset = 1'b1;
      #1;
      chk("arst_cmd", cmd, 8'h00);
      chk("arst_valid", cmd_valid, 0);
      chk("arst_count", fifo_count, 0);
      chk("arst_ovf", overflow, 0);
      chk("arst_hold", move_hold, 0);
      @(negedge clk);
      reset = 1'b0;
      send(8'h53, 1'b0);
      chk("S_cmd", cmd, 8'h02);
      chk("S_count", fifo_count, 1);
      chk("S_hold", move_hold, 4'b0010);
      send(8'h0D, 1'b0);
      chk("cr_count", fifo_count, 2);
      cmd_ready = 1'b1; @(negedge clk); cmd_ready = 1'b0;
      chk("cr_cmd", cmd, 8'h10);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
